// File: rtl/emb_row_reader.sv
// rtl/emb_row_reader.sv - streams the ROW_LEN words of one embedding row from a synchronous ROM
// Fetches stop while buffered plus in-flight words (net of this cycle's pop) would exceed the 2-entry FIFO.
module emb_row_reader #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 16,
  parameter int ROW_LEN = 24,
  parameter int N_ROWS  = 200,
  parameter int IDX_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_idx,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err
);
  localparam int K_W = $clog2(ROW_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            r_state;
  logic              r_req_ready;
  logic              r_err;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [K_W-1:0]    r_k;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic              r_fifo_last [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_accept;
  logic              w_in_range;
  logic              w_out_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_k_last;
  logic [1:0]        w_pending;
  logic [ADDR_W-1:0] w_base;

  assign w_accept    = req_valid & r_req_ready;
  assign w_in_range  = 32'(req_idx) < 32'(N_ROWS);
  assign w_base      = ADDR_W'(32'(req_idx) * 32'(ROW_LEN));
  assign w_out_valid = (r_count != 2'd0);
  assign w_pop       = w_out_valid & out_ready;
  // Occupancy after this edge's push and pop; also the next FIFO count.
  assign w_pending   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue     = (r_state == S_FETCH) && (w_pending < 2'd2);
  assign w_k_last    = (r_k == K_W'(ROW_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_req_ready     <= 1'b0;
      r_err           <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_rom_addr      <= '0;
      r_k             <= '0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last[0]  <= 1'b0;
      r_fifo_last[1]  <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      r_err           <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_k_last;
      r_count         <= w_pending;

      if (r_inflight) begin
        r_fifo_data[r_wr_ptr] <= rom_q;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept && w_in_range) begin
            r_rom_addr  <= w_base;
            r_k         <= '0;
            r_req_ready <= 1'b0;
            r_state     <= S_FETCH;
          end else begin
            r_err       <= w_accept;
            r_req_ready <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_rom_addr <= r_rom_addr + 1'b1;
            r_k        <= r_k + 1'b1;
            if (w_k_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && r_fifo_last[r_rd_ptr]) begin
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign err       = r_err;
  assign rom_addr  = r_rom_addr;
  assign out_valid = w_out_valid;
  assign out_data  = r_fifo_data[r_rd_ptr];
  assign out_last  = w_out_valid & r_fifo_last[r_rd_ptr];

endmodule

// File: tb/tb_emb_row_reader.sv
// tb/tb_emb_row_reader.sv - self-checking bench for emb_row_reader against a row-of-addresses model
module tb_emb_row_reader;
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 16;
  localparam int ROW_LEN = 24;
  localparam int N_ROWS  = 200;
  localparam int IDX_W   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [IDX_W-1:0]  req_idx = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              err;

  int n_total = 0;
  int n_bad = 0;

  int got_d[$];
  bit got_l[$];
  int got_c[$];
  int acc_c[$];
  int exp_d[$];
  int stall_bad;
  int ahead_bad;
  bit timed_out;

  emb_row_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_LEN(ROW_LEN), .N_ROWS(N_ROWS), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous ROM whose content equals its address.
  always @(posedge clk) rom_q <= DATA_W'(rom_addr);

  // Reference: a row is ROW_LEN consecutive addresses starting at idx*ROW_LEN.
  task automatic model_row(input int idx);
    for (int k = 0; k < ROW_LEN; k++) exp_d.push_back(idx * ROW_LEN + k);
  endtask

  // Drives requests and out_ready each cycle and records what was accepted; no checking here.
  task automatic run_row(input int idx_a, input int idx_b, input int rmode, input int stop_after);
    int pend[$];
    int base;
    int acc_row;
    int rows_left;
    bit active;
    bit prev_stall;
    logic [DATA_W-1:0] prev_d;
    logic prev_l;
    bit done;
    got_d.delete(); got_l.delete(); got_c.delete(); acc_c.delete();
    stall_bad = 0; ahead_bad = 0; timed_out = 0;
    pend.push_back(idx_a);
    if (idx_b >= 0) pend.push_back(idx_b);
    rows_left = pend.size();
    base = 0; acc_row = 0; active = 0; prev_stall = 0; done = 0;
    prev_d = '0; prev_l = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(negedge clk);
      if (prev_stall && !(out_valid === 1'b1 && out_data === prev_d && out_last === prev_l)) stall_bad++;
      if (active && (int'(rom_addr) - base - acc_row > 2)) ahead_bad++;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (n % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      req_valid = (pend.size() != 0);
      if (pend.size() != 0) req_idx = IDX_W'(pend[0]);
      if (req_valid && req_ready) begin
        acc_c.push_back(n);
        base = pend[0] * ROW_LEN;
        acc_row = 0;
        active = 1;
        pend.delete(0);
      end
      if (out_valid && out_ready) begin
        got_d.push_back(int'(out_data));
        got_l.push_back(out_last);
        got_c.push_back(n);
        acc_row++;
        if (out_last) begin
          active = 0;
          rows_left--;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      if ((stop_after > 0 && got_d.size() == stop_after) || (stop_after == 0 && rows_left == 0)) done = 1;
    end
    if (!done) timed_out = 1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_total++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_total++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    n_total++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    n_total++; if (rom_addr !== '0) begin n_bad++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
    rst_n = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL release_ready_early got=%b exp=0", req_ready); end
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready_rise got=%b exp=1", req_ready); end
  endtask

  task automatic test_stream;
    exp_d.delete(); model_row(3);
    run_row(3, -1, 0, 0);
    n_total++; if (timed_out) begin n_bad++; $display("FAIL stream_timeout got=1 exp=0"); end
    n_total++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL stream_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i % ROW_LEN == ROW_LEN - 1)) begin
        n_bad++; $display("FAIL stream_word[%0d] got=%0d/%0b exp=%0d/%0b", i, got_d[i], got_l[i], exp_d[i], i % ROW_LEN == ROW_LEN - 1);
      end
      n_total++;
      if (acc_c.size() > 0 && got_c[i] !== acc_c[0] + 3 + i) begin
        // acceptance edge ends cycle acc_c[0]; first word valid after the second following edge
        n_bad++; $display("FAIL stream_timing[%0d] got=%0d exp=%0d", i, got_c[i], acc_c[0] + 3 + i);
      end
    end
  endtask

  task automatic test_stall;
    exp_d.delete(); model_row(0);
    run_row(0, -1, 1, 0);
    n_total++; if (timed_out) begin n_bad++; $display("FAIL stall_timeout got=1 exp=0"); end
    n_total++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL stall_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i % ROW_LEN == ROW_LEN - 1)) begin
        n_bad++; $display("FAIL stall_word[%0d] got=%0d/%0b exp=%0d/%0b", i, got_d[i], got_l[i], exp_d[i], i % ROW_LEN == ROW_LEN - 1);
      end
    end
    n_total++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall_hold got=%0d exp=0", stall_bad); end
    n_total++; if (ahead_bad != 0) begin n_bad++; $display("FAIL stall_ahead got=%0d exp=0", ahead_bad); end
  endtask

  task automatic test_last_row;
    exp_d.delete(); model_row(N_ROWS - 1);
    run_row(N_ROWS - 1, -1, 0, 0);
    n_total++; if (timed_out) begin n_bad++; $display("FAIL lastrow_timeout got=1 exp=0"); end
    n_total++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL lastrow_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i % ROW_LEN == ROW_LEN - 1)) begin
        n_bad++; $display("FAIL lastrow_word[%0d] got=%0d/%0b exp=%0d/%0b", i, got_d[i], got_l[i], exp_d[i], i % ROW_LEN == ROW_LEN - 1);
      end
    end
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL lastrow_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_range_error(input int idx);
    int err_cnt = 0;
    int err_at = -1;
    int acc_at = -1;
    int ov = 0;
    int rdy_after = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (err === 1'b1) begin err_cnt++; if (err_at < 0) err_at = n; end
      if (out_valid !== 1'b0) ov++;
      if (acc_at >= 0 && n == acc_at + 1) rdy_after = int'(req_ready);
      out_ready = 1'b1;
      req_valid = (acc_at < 0);
      req_idx = IDX_W'(idx);
      if (req_valid && req_ready) acc_at = n;
    end
    req_valid = 1'b0;
    n_total++; if (acc_at < 0) begin n_bad++; $display("FAIL range_accept idx=%0d got=none exp=accepted", idx); end
    n_total++; if (err_cnt != 1) begin n_bad++; $display("FAIL range_err_cycles idx=%0d got=%0d exp=1", idx, err_cnt); end
    n_total++; if (err_at != acc_at + 1) begin n_bad++; $display("FAIL range_err_time idx=%0d got=%0d exp=%0d", idx, err_at, acc_at + 1); end
    n_total++; if (ov != 0) begin n_bad++; $display("FAIL range_out_valid idx=%0d got=%0d exp=0", idx, ov); end
    n_total++; if (rdy_after != 1) begin n_bad++; $display("FAIL range_ready idx=%0d got=%0d exp=1", idx, rdy_after); end
  endtask

  task automatic test_reset_mid_row;
    run_row(1, -1, 0, 5);
    n_total++; if (timed_out) begin n_bad++; $display("FAIL midrst_timeout got=1 exp=0"); end
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    n_total++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_req_ready got=%b exp=0", req_ready); end
    n_total++; if (rom_addr !== '0) begin n_bad++; $display("FAIL midrst_rom_addr got=%0d exp=0", rom_addr); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_no_resume got=%b exp=0", out_valid); end
    exp_d.delete(); model_row(2);
    run_row(2, -1, 2, 0);
    n_total++; if (timed_out) begin n_bad++; $display("FAIL midrst_row2_timeout got=1 exp=0"); end
    n_total++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL midrst_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i % ROW_LEN == ROW_LEN - 1)) begin
        n_bad++; $display("FAIL midrst_word[%0d] got=%0d/%0b exp=%0d/%0b", i, got_d[i], got_l[i], exp_d[i], i % ROW_LEN == ROW_LEN - 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_d.delete(); model_row(5); model_row(6);
    run_row(5, 6, 0, 0);
    n_total++; if (timed_out) begin n_bad++; $display("FAIL b2b_timeout got=1 exp=0"); end
    n_total++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i % ROW_LEN == ROW_LEN - 1)) begin
        n_bad++; $display("FAIL b2b_word[%0d] got=%0d/%0b exp=%0d/%0b", i, got_d[i], got_l[i], exp_d[i], i % ROW_LEN == ROW_LEN - 1);
      end
    end
    n_total++;
    if (acc_c.size() != 2 || got_c.size() < ROW_LEN) begin
      n_bad++; $display("FAIL b2b_accepts got=%0d exp=2", acc_c.size());
    end else if (acc_c[1] != got_c[ROW_LEN - 1] + 1) begin
      n_bad++; $display("FAIL b2b_second_accept got=%0d exp=%0d", acc_c[1], got_c[ROW_LEN - 1] + 1);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      int idx;
      idx = int'($urandom_range(0, N_ROWS - 1));
      exp_d.delete(); model_row(idx);
      run_row(idx, -1, 2, 0);
      n_total++; if (timed_out) begin n_bad++; $display("FAIL rand_timeout idx=%0d got=1 exp=0", idx); end
      n_total++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL rand_count idx=%0d got=%0d exp=%0d", idx, got_d.size(), exp_d.size()); end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        n_total++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== (i % ROW_LEN == ROW_LEN - 1)) begin
          n_bad++; $display("FAIL rand_word idx=%0d [%0d] got=%0d/%0b exp=%0d/%0b", idx, i, got_d[i], got_l[i], exp_d[i], i % ROW_LEN == ROW_LEN - 1);
        end
      end
      n_total++; if (stall_bad != 0) begin n_bad++; $display("FAIL rand_hold idx=%0d got=%0d exp=0", idx, stall_bad); end
      n_total++; if (ahead_bad != 0) begin n_bad++; $display("FAIL rand_ahead idx=%0d got=%0d exp=0", idx, ahead_bad); end
      if (r % 3 == 2) test_range_error(int'($urandom_range(N_ROWS, (1 << IDX_W) - 1)));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_last_row();
    test_range_error(N_ROWS);
    test_reset_mid_row();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
